decimal_entry: RTL
==================

Name: decimal_entry

Overview:
Operator-input front end for the CPU's input instruction. It is the reverse of the binary-to-BCD display path: it converts decimal digits keyed on the board switches and confirmed with the enter button into a 32-bit two's-complement binary value. It also performs a request/done handshake with the control unit. It sits between the board switches/button and the register-file write-data mux, and replaces direct sampling of the raw switch value.

Parameters:
DEBOUNCE_CYCLES, 16'd50000, consecutive stable clk cycles required to accept a button level change (range 1..65535)
MAX_DIGITS, 9, maximum accepted decimal digits (range 1..9); further digits are ignored

Ports:
clk  input  1  system clock (divided clock, same domain as the control unit)
reset  input  1  synchronous, active-high reset
btn_enter  input  1  raw enter button, active-high (already inverted at the pin), asynchronous
digit_in  input  4  switch[3:0]; 0-9 = digit, 4'hE = clear, 4'hF = commit, 4'hA-4'hD = ignored
neg_in  input  1  switch[15]; sign of the entry, sampled at commit
req  input  1  level signal from the control unit: input instruction waiting
busy  output  1  high while collecting digits
done  output  1  one-cycle pulse when value is updated
value  output  32  committed two's-complement result, held until the next commit
entry  output  32  live unsigned magnitude being typed (display echo)
digit_count  output  4  digits accepted so far

Behaviour:
- Reset (synchronous, active-high, clk): state IDLE; busy=0, done=0, value=0, entry=0, digit_count=0; synchronizers, debounce counter and stable level are cleared to 0. Reset mid-entry discards the entry and raises no done.
- Input conditioning: btn_enter, digit_in and neg_in each pass through a 2-flop synchronizer.
- Debounce: the stable level changes only after the synchronized button differs from it for DEBOUNCE_CYCLES consecutive cycles. Any glitch restarts the count.
- press is a one-cycle pulse on the stable level's 0->1 edge. For a clean rising edge, press is high DEBOUNCE_CYCLES+2 cycles after the edge. One press is generated per physical press; holding the button generates no repeats.
- The digit and sign are taken from the synchronized switches in the press cycle.
- State IDLE: presses are ignored. When req=1, go to COLLECT and clear entry and digit_count to 0. busy=1 from the next cycle.
- State COLLECT, on press:
  - Digit 0-9 with digit_count<MAX_DIGITS: entry <= entry*10 + digit (32-bit unsigned; no overflow possible for MAX_DIGITS<=9); digit_count++.
  - Digit 0-9 with digit_count==MAX_DIGITS: ignored.
  - 4'hE: entry=0, digit_count=0; stay in COLLECT.
  - 4'hF: value <= neg ? (~entry+1) : entry; go to DONE. Committing with zero digits gives value=0, and a negative zero is also 0.
  - 4'hA-4'hD: ignored.
- State COLLECT, req falls: abort to IDLE. value is unchanged, no done. If req=0 and press occur in the same cycle, the abort wins.
- State DONE: done=1 for exactly this cycle; busy=0. Next state is WAIT_REQ_LOW. value is valid in the same cycle as done and afterwards.
- State WAIT_REQ_LOW: stay until req=0, then go to IDLE. This prevents a held req from restarting collection. entry and digit_count hold their values for display.
- The control unit writes value to the register file on the done cycle or later, then drops req.

Decomposition:
- Shared package: the state encoding (IDLE, COLLECT, DONE, WAIT_REQ_LOW, 2 bits) and the key-code constants KEY_CLEAR=4'hE and KEY_COMMIT=4'hF. The control unit and the assembler notes reuse these.
- One sub-module, button_debounce: synchronizer, counter, stable level and press pulse, parameterized by DEBOUNCE_CYCLES. It is reusable for the reset and other buttons.
- The multiply-by-10 is implemented as (x<<3)+(x<<1) inline.

Test Plan (DEBOUNCE_CYCLES=4, MAX_DIGITS=3 unless noted):
- req=1; press digits 1,2,3 then F with neg_in=0 -> entry steps 1,12,123; value=123; one done pulse; busy falls.
- req=1; digits 4,2, neg_in=1, press F -> value=32'hFFFFFFD6 (-42). Then press F with no digits -> value=0 (no negative zero).
- Press digits 9,9,9,9 then F -> fourth digit ignored, digit_count=3, value=999. Also press E after two digits -> entry=0, count=0.
- Button bounce: 3-cycle high glitches then a clean 20-cycle press -> exactly one press, DEBOUNCE_CYCLES+2 cycles after the clean edge. A 200-cycle hold -> no repeat.
- Abort and hold: drop req mid-entry -> IDLE, value unchanged, no done. Keep req high after done -> stays in WAIT_REQ_LOW and presses are ignored until req=0.
- Reset asserted mid-COLLECT, including in a press cycle -> all outputs 0 next cycle, no done. MAX_DIGITS=9 entry 999999999 -> value=32'h3B9AC9FF.

Source files
------------

// File: rtl/decimal_entry_pkg.sv
// Shared definitions for the decimal keypad entry front end: FSM state
// encoding and the special key codes read from switch[3:0].
package decimal_entry_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    COLLECT      = 2'd1,
    DONE         = 2'd2,
    WAIT_REQ_LOW = 2'd3
  } state_e;

  localparam logic [3:0] KEY_CLEAR  = 4'hE;
  localparam logic [3:0] KEY_COMMIT = 4'hF;
  localparam logic [3:0] KEY_MAX_DIGIT = 4'd9;

  // Codes 0-9 are decimal digits; everything above is a command or ignored.
  function automatic logic is_digit(input logic [3:0] key);
    return key <= KEY_MAX_DIGIT;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronizes a raw asynchronous button, debounces it and emits a single
// one-cycle pulse on each accepted 0->1 transition of the stable level.
module button_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  logic        sync1_q, sync2_q;
  logic        stable_q;
  logic        press_q;
  logic [15:0] cnt_q;

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // The stable level follows the synchronized button only after it has
  // differed for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      press_q <= 1'b0;
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
        cnt_q    <= '0;
        stable_q <= sync2_q;
        press_q  <= sync2_q;
      end else begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/decimal_entry.sv
// Decimal keypad entry: collects up to MAX_DIGITS decimal digits keyed on
// the switches and confirmed with the enter button, then commits a signed
// 32-bit value under a req/done handshake with the control unit.
module decimal_entry
  import decimal_entry_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter int          MAX_DIGITS      = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_enter,
  input  logic [3:0]  digit_in,
  input  logic        neg_in,
  input  logic        req,
  output logic        busy,
  output logic        done,
  output logic [31:0] value,
  output logic [31:0] entry,
  output logic [3:0]  digit_count
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

  logic               press;
  logic [3:0]         digit_s1_q, digit_s2_q;
  logic               neg_s1_q, neg_s2_q;
  state_e             state_q, state_d;
  logic [31:0]        entry_q, entry_d;
  logic [3:0]         count_q, count_d;
  logic signed [31:0] value_q, value_d;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_enter_debounce (
    .clk_i  (clk),
    .rst_i  (reset),
    .btn_i  (btn_enter),
    .press_o(press)
  );

  // Two-flop synchronizers for the digit and sign switches.
  always_ff @(posedge clk) begin
    if (reset) begin
      digit_s1_q <= '0;
      digit_s2_q <= '0;
      neg_s1_q   <= 1'b0;
      neg_s2_q   <= 1'b0;
    end else begin
      digit_s1_q <= digit_in;
      digit_s2_q <= digit_s1_q;
      neg_s1_q   <= neg_in;
      neg_s2_q   <= neg_s1_q;
    end
  end

  // Next-state and datapath decisions; a falling req in COLLECT beats a press.
  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    count_d = count_q;
    value_d = value_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = COLLECT;
          entry_d = '0;
          count_d = '0;
        end
      end
      COLLECT: begin
        if (!req) begin
          state_d = IDLE;
        end else if (press) begin
          if (is_digit(digit_s2_q)) begin
            if (count_q < MAX_CNT) begin
              entry_d = (entry_q << 3) + (entry_q << 1) + {28'd0, digit_s2_q};
              count_d = count_q + 4'd1;
            end
          end else if (digit_s2_q == KEY_CLEAR) begin
            entry_d = '0;
            count_d = '0;
          end else if (digit_s2_q == KEY_COMMIT) begin
            // Two's-complement negate; a negative zero folds back to 0.
            value_d = neg_s2_q ? signed'(~entry_q + 32'd1) : signed'(entry_q);
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = WAIT_REQ_LOW;
      end
      WAIT_REQ_LOW: begin
        if (!req) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      entry_q <= '0;
      count_q <= '0;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      count_q <= count_d;
      value_q <= value_d;
    end
  end

  assign busy        = (state_q == COLLECT);
  assign done        = (state_q == DONE);
  assign value       = value_q;
  assign entry       = entry_q;
  assign digit_count = count_q;

endmodule
